fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction prefetch unit for the multi-cycle core. It replaces the core's FETCH/FETCH_IMM/FETCH_IMEM byte-by-byte memory round trips with a byte FIFO that is filled one aligned 32-bit word at a time. It presents a 6-byte window to the decoder, which consumes between 0 and 6 bytes per cycle. A redirect from the execute stage flushes the queue and restarts fetching at any byte address.

## Interface
- `ADDR_WIDTH`, 32, width of byte addresses.
- `DEPTH`, 16, FIFO capacity in bytes; power of two, ≥ 8.
- `RESET_PC`, 0, byte address fetched after reset.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_req` out 1: word read request; held until `mem_ready`.
- `mem_addr` out ADDR_WIDTH: word-aligned address (`[1:0]` = 0); stable while `mem_req` is high.
- `mem_ready` in 1: request accepted; `mem_rdata` valid this cycle.
- `mem_rdata` in 32: little-endian word; byte 0 = `[7:0]`.
- `win_bytes` out 48: byte i = FIFO entry i; entries ≥ `win_count` read as 0.
- `win_count` out $clog2(DEPTH+1): valid bytes in FIFO.
- `win_pc` out ADDR_WIDTH: byte address of `win_bytes[7:0]`.
- `consume_len` in 3: bytes removed this cycle (0–6).
- `underflow` out 1: one-cycle pulse when `consume_len` > min(`win_count`, 6).
- `redirect` in 1: flush the FIFO and restart fetching at `redirect_pc`.
- `redirect_pc` in ADDR_WIDTH: new byte address.

## Operation
- States: IDLE, REQ, DROP.
  - IDLE → REQ when free space (DEPTH − count, after this cycle's consume/write) ≥ 4 and no redirect.
  - REQ → IDLE on `mem_ready`.
  - REQ → DROP on `redirect` without `mem_ready`.
  - DROP → IDLE on `mem_ready`; the returned data is discarded.
- `mem_req` and `mem_addr` are registered and never withdrawn mid-handshake.
- Fetch pointer `fptr` is the next word address, incremented by 4 per accepted word. It wraps modulo 2^ADDR_WIDTH.
- Skip count `skip`, 0–3, is set to `redirect_pc[1:0]` on redirect. The first word accepted after a redirect writes only bytes `skip`..3; `skip` is then cleared. Every other word writes 4 bytes.
- Consume: if `consume_len` ≤ min(`win_count`, 6), remove `consume_len` bytes and add `consume_len` to `win_pc`. Otherwise remove nothing and pulse `underflow`.
- Write and consume in the same cycle are both applied. `count_next` = count − consumed + written, and never exceeds DEPTH, because a request is only issued with ≥ 4 bytes free.
- Redirect has priority over everything in the same cycle:
  - count becomes 0, `win_pc` becomes `redirect_pc`, `fptr` becomes `redirect_pc` & ~3.
  - Consume is ignored and `underflow` is not raised.
  - A word returned in the same cycle is discarded.
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally.

## Timing
- Reset values:
  - `mem_req` 0, `mem_addr` = `RESET_PC` & ~3.
  - `win_count` 0, `win_bytes` 0, `win_pc` `RESET_PC`, `underflow` 0.
  - State IDLE, `skip` = `RESET_PC[1:0]`.
  - Statistics counters 0.
- Request timing: `mem_req` rises on the first edge after reset is released. In general it rises one cycle after IDLE sees sufficient space.
- Data timing: a word accepted at edge N (`mem_ready` high) is visible in `win_count`/`win_bytes` after edge N.
- Best-case throughput: one word every 2 cycles (REQ, then IDLE).
- Redirect latency: new `mem_req` one cycle after the redirect edge from IDLE or REQ+ready. From DROP it follows the discarded response.
- A second redirect while in DROP updates the target again and keeps DROP.
- Reset asserted mid-handshake drops `mem_req` immediately; the memory side must tolerate this.

## Configuration
- `FETCH_UNIT_STATS_EN` defined: adds two 32-bit wrapping output ports, both cleared by reset.
  - `stat_words`: words accepted and written.
  - `stat_stalls`: cycles with `win_count` < 6 and no redirect.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

## Test plan
- Reset with `RESET_PC` = 0x100, memory returning ready the cycle after each request, `consume_len` 0:
  - addresses 0x100, 0x104, 0x108, 0x10C are fetched;
  - `win_count` = 16 and `mem_req` stays low while full.
- Redirect to 0x203, word 0x203 = 0xDDCCBBAA, next word 0x44332211:
  - first write adds 1 byte (0xDD); `win_pc` = 0x203;
  - after the next word, `win_bytes[39:0]` = 0x44332211DD.
- Redirect while REQ is waiting 3 cycles for ready:
  - the old word is dropped and `mem_req` stays high through DROP;
  - the next request addresses the new target; the FIFO contains only new-target bytes.
- `win_count` = 3, `consume_len` = 5 → `underflow` pulses for one cycle; `win_count` stays 3 and `win_pc` is unchanged.
- Simultaneous consume 2 and word write with count 6 → count 8; `win_pc` advances by 2.
- With `FETCH_UNIT_STATS_EN`: 10 accepted words, one of them discarded in DROP → `stat_words` = 9.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction prefetch unit: fills a byte FIFO one aligned word at a time and presents a 6-byte decode window.
// Optional statistics ports are built when FETCH_UNIT_STATS_EN is defined.
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic                           mem_req,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    input  logic                           mem_ready,
    input  logic [31:0]                    mem_rdata,
    output logic [47:0]                    win_bytes,
    output logic [$clog2(DEPTH+1)-1:0]     win_count,
    output logic [ADDR_WIDTH-1:0]          win_pc,
    input  logic [2:0]                     consume_len,
    output logic                           underflow,
    input  logic                           redirect,
    input  logic [ADDR_WIDTH-1:0]          redirect_pc
`ifdef FETCH_UNIT_STATS_EN
    ,
    output logic [31:0]                    stat_words,
    output logic [31:0]                    stat_stalls
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] RESET_WORD = {RESET_PC[ADDR_WIDTH-1:2], 2'b00};

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic [PW-1:0]         rptr;
    logic [PW-1:0]         wptr;
    logic [ADDR_WIDTH-1:0] fptr;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  mem_req_q;
    logic [1:0]            skip;
    logic                  underflow_q;

    logic [2:0]            avail;
    logic                  cons_ok;
    logic [2:0]            consumed;
    logic                  wr_en;
    logic [2:0]            wr_len;
    logic                  space_ok;

    logic [7:0]            fifo [DEPTH];

    // Consume/write bookkeeping for this cycle; redirect overrides both.
    always_comb begin
        avail      = (count > CW'(6)) ? 3'd6 : count[2:0];
        cons_ok    = !redirect && (consume_len <= avail);
        consumed   = cons_ok ? consume_len : 3'd0;
        wr_en      = (state == REQ) && mem_ready && !redirect;
        wr_len     = wr_en ? (3'd4 - {1'b0, skip}) : 3'd0;
        count_next = redirect ? '0 : (count - CW'(consumed) + CW'(wr_len));
        space_ok   = (count_next <= CW'(DEPTH - 4));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (!redirect && space_ok) state_next = REQ;
            REQ: begin
                if (mem_ready)     state_next = IDLE;
                else if (redirect) state_next = DROP;
            end
            // A redirect here only retargets; the outstanding response still has to drain.
            DROP: if (mem_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            rptr        <= '0;
            wptr        <= '0;
            fptr        <= RESET_WORD;
            pc_q        <= RESET_PC;
            mem_addr_q  <= RESET_WORD;
            mem_req_q   <= 1'b0;
            skip        <= RESET_PC[1:0];
            underflow_q <= 1'b0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            mem_req_q   <= (state_next != IDLE);
            underflow_q <= !redirect && (consume_len > avail);
            if (state == IDLE && state_next == REQ)
                mem_addr_q <= fptr;
            if (redirect) begin
                rptr <= wptr;
                pc_q <= redirect_pc;
                fptr <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
                skip <= redirect_pc[1:0];
            end else begin
                rptr <= rptr + PW'(consumed);
                pc_q <= pc_q + ADDR_WIDTH'(consumed);
                if (wr_en) begin
                    wptr <= wptr + PW'(wr_len);
                    fptr <= fptr + ADDR_WIDTH'(4);
                    skip <= 2'd0;
                end
            end
        end
    end

    // Byte storage carries no reset; the window masks entries beyond count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (2'(k) >= skip)
                    fifo[wptr + PW'(k) - PW'(skip)] <= mem_rdata[8*k +: 8];
            end
        end
    end

    always_comb begin
        win_bytes = '0;
        for (int i = 0; i < 6; i++) begin
            if (CW'(i) < count)
                win_bytes[8*i +: 8] = fifo[rptr + PW'(i)];
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign win_count = count;
    assign win_pc    = pc_q;
    assign underflow = underflow_q;

`ifdef FETCH_UNIT_STATS_EN
    logic [31:0] stat_words_q;
    logic [31:0] stat_stalls_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_words_q  <= '0;
            stat_stalls_q <= '0;
        end else begin
            if (wr_en)
                stat_words_q <= stat_words_q + 32'd1;
            if (!redirect && (count < CW'(6)))
                stat_stalls_q <= stat_stalls_q + 32'd1;
        end
    end

    assign stat_words  = stat_words_q;
    assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory responder plus an address scoreboard, with directed window checks.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [47:0] win_bytes;
    logic [4:0]  win_count;
    logic [31:0] win_pc;
    logic [2:0]  consume_len = '0;
    logic        underflow;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
`ifdef FETCH_UNIT_STATS_EN
    logic [31:0] stat_words;
    logic [31:0] stat_stalls;
`endif

    int errors = 0;
    int checks = 0;
    int lat    = 0;
    int wcnt   = 0;
    bit hold   = 1'b0;
    logic [31:0] exp_addr [$];

    fetch_unit #(.ADDR_WIDTH(32), .DEPTH(16), .RESET_PC(32'h100)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .win_bytes(win_bytes), .win_count(win_count), .win_pc(win_pc),
        .consume_len(consume_len), .underflow(underflow),
        .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef FETCH_UNIT_STATS_EN
        , .stat_words(stat_words), .stat_stalls(stat_stalls)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h200) return 32'hDDCCBBAA;
        if (a == 32'h204) return 32'h44332211;
        return {a[7:0] + 8'd3, a[7:0] + 8'd2, a[7:0] + 8'd1, a[7:0]};
    endfunction

    // Memory model: answers after lat waiting cycles unless held off.
    always @(posedge clk) begin
        #2;
        if (mem_req && !hold && wcnt >= lat) begin
            mem_ready = 1'b1;
            mem_rdata = word_at(mem_addr);
            wcnt = 0;
        end else begin
            mem_ready = 1'b0;
            wcnt = mem_req ? wcnt + 1 : 0;
        end
    end

    // Scoreboard monitor: each completed handshake must match the next expected address.
    always @(negedge clk) begin
        if (!rst && mem_req && mem_ready) begin
            checks++;
            if (exp_addr.size() == 0) begin
                errors++;
                $display("FAIL mem_addr: unexpected request at %h", mem_addr);
            end else begin
                logic [31:0] e;
                e = exp_addr.pop_front();
                if (mem_addr !== e) begin
                    errors++;
                    $display("FAIL mem_addr: got %h expected %h", mem_addr, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_count(input int n);
        for (int k = 0; k < 200 && win_count != 5'(n); k++) tick();
        chk("wait_count", 64'(win_count), 64'(n));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'h100);
        chk("rst_win_count", 64'(win_count), 64'd0);
        chk("rst_win_bytes", 64'(win_bytes), 64'd0);
        chk("rst_win_pc", 64'(win_pc), 64'h100);
        chk("rst_underflow", 64'(underflow), 64'd0);

        // Fill from RESET_PC until full
        exp_addr.push_back(32'h100); exp_addr.push_back(32'h104);
        exp_addr.push_back(32'h108); exp_addr.push_back(32'h10C);
        rst = 1'b0;
        tick();
        chk("first_req", 64'(mem_req), 64'd1);
        chk("first_addr", 64'(mem_addr), 64'h100);
        wait_count(16);
        chk("full_bytes", 64'(win_bytes), 64'h050403020100);
        chk("full_pc", 64'(win_pc), 64'h100);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("full_no_req", 64'(mem_req), 64'd0);
        end

        // Redirect to unaligned 0x203
        exp_addr.push_back(32'h200); exp_addr.push_back(32'h204);
        exp_addr.push_back(32'h208); exp_addr.push_back(32'h20C);
        redirect = 1'b1; redirect_pc = 32'h203;
        tick();
        redirect = 1'b0;
        chk("redir_count", 64'(win_count), 64'd0);
        chk("redir_pc", 64'(win_pc), 64'h203);
        wait_count(1);
        chk("skip_bytes", 64'(win_bytes), 64'hDD);
        chk("skip_pc", 64'(win_pc), 64'h203);
        wait_count(5);
        chk("skip_bytes2", 64'(win_bytes), 64'h0044332211DD);
        wait_count(13);

        // Redirect while a request waits for a slow memory
        lat = 3;
        exp_addr.push_back(32'h210);
        consume_len = 3'd2;
        tick();
        consume_len = 3'd0;
        chk("slow_req", 64'(mem_req), 64'd1);
        chk("slow_addr", 64'(mem_addr), 64'h210);
        chk("slow_count", 64'(win_count), 64'd11);
        chk("slow_pc", 64'(win_pc), 64'h205);
        redirect = 1'b1; redirect_pc = 32'h502;
        tick();
        redirect = 1'b0;
        chk("drop_req", 64'(mem_req), 64'd1);
        chk("drop_count", 64'(win_count), 64'd0);
        chk("drop_pc", 64'(win_pc), 64'h502);
        for (int k = 0; k < 20 && mem_req; k++) begin
            tick();
            chk("drop_empty", 64'(win_count), 64'd0);
        end
        chk("drop_done", 64'(mem_req), 64'd0);
        lat = 0;
        exp_addr.push_back(32'h500); exp_addr.push_back(32'h504);
        exp_addr.push_back(32'h508); exp_addr.push_back(32'h50C);
        wait_count(14);
        chk("new_bytes", 64'(win_bytes), 64'h070605040302);
        chk("new_pc", 64'(win_pc), 64'h502);

        // Underflow with three bytes held
        hold = 1'b1;
        exp_addr.push_back(32'h510);
        consume_len = 3'd6;
        tick();
        consume_len = 3'd5;
        tick();
        chk("c3_count", 64'(win_count), 64'd3);
        chk("c3_bytes", 64'(win_bytes), 64'h0F0E0D);
        chk("c3_pc", 64'(win_pc), 64'h50D);
        chk("c3_underflow", 64'(underflow), 64'd0);
        tick();
        consume_len = 3'd0;
        chk("uf_pulse", 64'(underflow), 64'd1);
        chk("uf_count", 64'(win_count), 64'd3);
        chk("uf_pc", 64'(win_pc), 64'h50D);
        tick();
        chk("uf_clear", 64'(underflow), 64'd0);

        // Simultaneous consume and word write
        consume_len = 3'd1;
        tick();
        consume_len = 3'd0;
        hold = 1'b0;
        tick();
        hold = 1'b1;
        chk("w1_count", 64'(win_count), 64'd6);
        exp_addr.push_back(32'h514);
        tick();
        chk("w2_addr", 64'(mem_addr), 64'h514);
        consume_len = 3'd2;
        hold = 1'b0;
        tick();
        consume_len = 3'd0;
        chk("cw_count", 64'(win_count), 64'd8);
        chk("cw_pc", 64'(win_pc), 64'h510);
        chk("cw_bytes", 64'(win_bytes), 64'h151413121110);

        exp_addr.push_back(32'h518); exp_addr.push_back(32'h51C);
        wait_count(16);
        for (int k = 0; k < 3; k++) tick();
        chk("end_no_req", 64'(mem_req), 64'd0);
        chk("queue_drained", 64'(exp_addr.size()), 64'd0);
`ifdef FETCH_UNIT_STATS_EN
        chk("stat_words", 64'(stat_words), 64'd16);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
